// File: rtl/taus_pkg.sv
// Shared constants, types and helpers for the taus88 generator bank.
// Shift amounts, masks, default seeds, seed minimums and FSM states.
package taus_pkg;

    localparam logic [31:0] MASK0 = 32'hFFFF_FFFE;
    localparam logic [31:0] MASK1 = 32'hFFFF_FFF8;
    localparam logic [31:0] MASK2 = 32'hFFFF_FFF0;

    localparam int SH0A = 13;
    localparam int SH0B = 19;
    localparam int SH0C = 12;
    localparam int SH1A = 2;
    localparam int SH1B = 25;
    localparam int SH1C = 4;
    localparam int SH2A = 3;
    localparam int SH2B = 11;
    localparam int SH2C = 17;

    localparam logic [31:0] DEF_S0 = 32'd12345;
    localparam logic [31:0] DEF_S1 = 32'd67890;
    localparam logic [31:0] DEF_S2 = 32'd13579;

    localparam logic [31:0] MIN_S0 = 32'd2;
    localparam logic [31:0] MIN_S1 = 32'd8;
    localparam logic [31:0] MIN_S2 = 32'd16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RUN
    } state_t;

    typedef struct packed {
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] s2;
    } taus_state_t;

    function automatic taus_state_t default_seed(input int c);
        taus_state_t r;
        r.s0 = DEF_S0 + 32'(c);
        r.s1 = DEF_S1 + 32'(c);
        r.s2 = DEF_S2 + 32'(c);
        return r;
    endfunction

    // Words below the taus88 minimum would lock the generator; use defaults.
    function automatic taus_state_t clamp_seed(input taus_state_t w,
                                               input taus_state_t d);
        taus_state_t r;
        r.s0 = (w.s0 < MIN_S0) ? d.s0 : w.s0;
        r.s1 = (w.s1 < MIN_S1) ? d.s1 : w.s1;
        r.s2 = (w.s2 < MIN_S2) ? d.s2 : w.s2;
        return r;
    endfunction

endpackage

// File: rtl/taus88_step.sv
// One combinational taus88 state update for a single channel.
// Three Tausworthe components, 32-bit arithmetic with truncation.
module taus88_step
    import taus_pkg::*;
(
    input  taus_state_t cur,
    output taus_state_t nxt
);

    logic [31:0] b0;
    logic [31:0] b1;
    logic [31:0] b2;

    // Feedback terms and shifted, masked states for each component
    always_comb begin
        b0 = ((cur.s0 << SH0A) ^ cur.s0) >> SH0B;
        b1 = ((cur.s1 << SH1A) ^ cur.s1) >> SH1B;
        b2 = ((cur.s2 << SH2A) ^ cur.s2) >> SH2B;
        nxt.s0 = ((cur.s0 & MASK0) << SH0C) ^ b0;
        nxt.s1 = ((cur.s1 & MASK1) << SH1C) ^ b1;
        nxt.s2 = ((cur.s2 & MASK2) << SH2C) ^ b2;
    end

endmodule

// File: rtl/taus_urng_bank.sv
// Bank of N_CH taus88 uniform generators with warm-up and handshake.
// All channels share one step enable so they advance in lockstep.
module taus_urng_bank
    import taus_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int OUT_W  = 32,
    parameter int WARMUP = 16
) (
    input  logic                                    clock,
    input  logic                                    re_set,
    input  logic                                    seed_wr,
    input  logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] seed_ch,
    input  logic [31:0]                             seed_s0,
    input  logic [31:0]                             seed_s1,
    input  logic [31:0]                             seed_s2,
    input  logic                                    start,
    input  logic                                    halt,
    input  logic                                    out_ready,
    output logic                                    out_valid,
    output logic [N_CH*OUT_W-1:0]                   out_data,
    output logic                                    busy
);

    localparam logic [7:0] WLAST = (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;

    state_t      state;
    logic [7:0]  cnt;
    logic        step;
    logic        seed_ok;
    taus_state_t seed_word;

    assign seed_word = '{s0: seed_s0, s1: seed_s1, s2: seed_s2};

    assign step = !halt &&
                  ((state == ST_WARMUP) ||
                   (state == ST_RUN && out_valid && out_ready));

    assign seed_ok = (state == ST_IDLE) && seed_wr &&
                     (32'(seed_ch) < 32'(N_CH));

    // Control FSM with registered out_valid and busy
    always_ff @(posedge clock) begin
        if (re_set) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt <= 8'd0;
                        if (WARMUP == 0) begin
                            state     <= ST_RUN;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ST_WARMUP;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_WARMUP: begin
                    if (halt) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == WLAST) begin
                        state     <= ST_RUN;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_RUN: begin
                    if (halt) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        localparam taus_state_t DEF = default_seed(c);

        taus_state_t cur;
        taus_state_t nxt;
        logic [31:0] res;
        logic        load;

        assign load = seed_ok && (32'(seed_ch) == 32'(c));

        taus88_step u_step (
            .cur (cur),
            .nxt (nxt)
        );

        // Channel state: defaults on reset, seeds in IDLE, shared step enable
        always_ff @(posedge clock) begin
            if (re_set) begin
                cur <= DEF;
            end else if (load) begin
                cur <= clamp_seed(seed_word, DEF);
            end else if (step) begin
                cur <= nxt;
            end
        end

        assign res = cur.s0 ^ cur.s1 ^ cur.s2;
        assign out_data[c*OUT_W +: OUT_W] = res[31 -: OUT_W];
    end

endmodule

// File: tb/tb_taus_urng_bank.sv
// Directed self-checking bench for taus_urng_bank (N_CH=4, OUT_W=32).
// Golden taus88 states are tracked per channel in the bench.
module tb_taus_urng_bank;

    localparam int NC = 4;
    localparam int W  = 32;

    logic          clock = 1'b0;
    logic          re_set;
    logic          seed_wr;
    logic [1:0]    seed_ch;
    logic [31:0]   seed_s0;
    logic [31:0]   seed_s1;
    logic [31:0]   seed_s2;
    logic          start;
    logic          halt;
    logic          out_ready;
    logic          out_valid;
    logic [NC*W-1:0] out_data;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] g0 [NC];
    logic [31:0] g1 [NC];
    logic [31:0] g2 [NC];

    taus_urng_bank #(
        .N_CH   (NC),
        .OUT_W  (W),
        .WARMUP (16)
    ) dut (
        .clock     (clock),
        .re_set    (re_set),
        .seed_wr   (seed_wr),
        .seed_ch   (seed_ch),
        .seed_s0   (seed_s0),
        .seed_s1   (seed_s1),
        .seed_s2   (seed_s2),
        .start     (start),
        .halt      (halt),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] t0(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 13) ^ s) >> 19;
        return ((s & 32'hFFFFFFFE) << 12) ^ b;
    endfunction

    function automatic logic [31:0] t1(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 2) ^ s) >> 25;
        return ((s & 32'hFFFFFFF8) << 4) ^ b;
    endfunction

    function automatic logic [31:0] t2(input logic [31:0] s);
        logic [31:0] b;
        b = ((s << 3) ^ s) >> 11;
        return ((s & 32'hFFFFFFF0) << 17) ^ b;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic gold_step();
        for (int c = 0; c < NC; c++) begin
            g0[c] = t0(g0[c]);
            g1[c] = t1(g1[c]);
            g2[c] = t2(g2[c]);
        end
    endtask

    task automatic gold_defaults();
        for (int c = 0; c < NC; c++) begin
            g0[c] = 32'd12345 + 32'(c);
            g1[c] = 32'd67890 + 32'(c);
            g2[c] = 32'd13579 + 32'(c);
        end
    endtask

    task automatic check_all(input string name);
        logic [31:0] exp;
        logic [31:0] got;
        for (int c = 0; c < NC; c++) begin
            exp = g0[c] ^ g1[c] ^ g2[c];
            got = out_data[c*W +: W];
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s ch%0d got %h expected %h",
                         name, c, got, exp);
            end
        end
    endtask

    task automatic test_reset();
        re_set = 1'b1;
        tick();
        re_set = 1'b0;
        gold_defaults();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got valid=%b busy=%b expected 0/0",
                     out_valid, busy);
        end
        check_all("reset_data");
        tick();
        tick();
        check_all("idle_hold");
    endtask

    task automatic test_warmup();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (busy !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL warmup_busy cyc%0d got busy=%b valid=%b expected 1/0",
                         i + 1, busy, out_valid);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL warmup_end got busy=%b valid=%b expected 0/1",
                     busy, out_valid);
        end
        repeat (16) gold_step();
        check_all("warmup_data");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("stall_hold");
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            gold_step();
            check_all("beat");
        end
        out_ready = 1'b0;
    endtask

    task automatic test_seed_clamp();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_valid got %b expected 0", out_valid);
        end
        seed_wr = 1'b1;
        seed_ch = 2'd1;
        seed_s0 = 32'd1;
        seed_s1 = 32'd100;
        seed_s2 = 32'd3;
        tick();
        seed_wr = 1'b0;
        g0[1] = 32'd12346;
        g1[1] = 32'd100;
        g2[1] = 32'd13580;
        check_all("seed_clamp");
    endtask

    task automatic test_seed_start_halt();
        seed_wr = 1'b1;
        start   = 1'b1;
        seed_ch = 2'd0;
        seed_s0 = 32'd1000;
        seed_s1 = 32'd2000;
        seed_s2 = 32'd3000;
        tick();
        seed_wr = 1'b0;
        start   = 1'b0;
        g0[0] = 32'd1000;
        g1[0] = 32'd2000;
        g2[0] = 32'd3000;
        repeat (16) tick();
        repeat (16) gold_step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL seedstart_valid got %b expected 1", out_valid);
        end
        check_all("seedstart_data");
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            gold_step();
            check_all("seedstart_beat");
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_run got valid=%b expected 0", out_valid);
        end
        check_all("halt_nostep");
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (16) tick();
        repeat (16) gold_step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL resume_valid got %b expected 1", out_valid);
        end
        check_all("resume_data");
    endtask

    task automatic test_reset_in_run();
        seed_wr = 1'b1;
        seed_ch = 2'd2;
        seed_s0 = 32'd5000;
        seed_s1 = 32'd6000;
        seed_s2 = 32'd7000;
        tick();
        seed_wr = 1'b0;
        check_all("seed_in_run");
        re_set    = 1'b1;
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        re_set    = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        gold_defaults();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL run_reset got valid=%b busy=%b expected 0/0",
                     out_valid, busy);
        end
        check_all("run_reset_data");
    endtask

    initial begin
        re_set    = 1'b1;
        seed_wr   = 1'b0;
        seed_ch   = 2'd0;
        seed_s0   = 32'd0;
        seed_s1   = 32'd0;
        seed_s2   = 32'd0;
        start     = 1'b0;
        halt      = 1'b0;
        out_ready = 1'b0;
        tick();
        test_reset();
        test_warmup();
        test_backpressure();
        test_seed_clamp();
        test_seed_start_halt();
        test_reset_in_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/taus_urng_bank.md
TAUS_URNG_BANK -- requirements
Module: taus_urng_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of independent taus88 generator channels (1..16).
REQ-002 SHALL have parameter OUT_W, default 32, meaning output bits per channel (1..32); the OUT_W MSBs of each channel's 32-bit result are output.
REQ-003 SHALL have parameter WARMUP, default 16, meaning number of discarded steps after start (0..255).
REQ-004 SHALL have port clock, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port re_set, input, 1, meaning synchronous, active-high reset.
REQ-006 SHALL have port seed_wr, input, 1, meaning a seed-write strobe.
REQ-007 SHALL have port seed_ch, input, $clog2(N_CH) (min 1), meaning the target channel index.
REQ-008 SHALL have ports seed_s0, seed_s1 and seed_s2, input, 32 each, meaning the seed words.
REQ-009 SHALL have port start, input, 1, meaning begin warm-up, then run.
REQ-010 SHALL have port halt, input, 1, meaning return to IDLE with generator state preserved.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer accepts out_data.
REQ-012 SHALL have port out_valid, output, 1, meaning out_data is valid.
REQ-013 SHALL have port out_data, output, N_CH*OUT_W, meaning channel c occupies bits [c*OUT_W +: OUT_W].
REQ-014 SHALL have port busy, output, 1, meaning high while in state WARMUP.

Function
REQ-015 SHALL, for each channel, perform one taus88 step:
- b=((s0<<13)^s0)>>19; s0=((s0&FFFFFFFE)<<12)^b
- b=((s1<<2)^s1)>>25; s1=((s1&FFFFFFF8)<<4)^b
- b=((s2<<3)^s2)>>11; s2=((s2&FFFFFFF0)<<17)^b
- all arithmetic is 32-bit with truncation.
REQ-016 SHALL define the channel result as s0^s1^s2 of the current registered state; out_data is combinational from the state registers (zero latency from state to output).
REQ-017 SHALL implement FSM states IDLE, WARMUP and RUN.
REQ-018 SHALL, in IDLE, hold out_valid=0, not step, and accept seed_wr.
REQ-019 SHALL, on start in IDLE, go to WARMUP with the counter = 0; if WARMUP==0, go directly to RUN.
REQ-020 SHALL, in WARMUP, step all channels every cycle, hold out_valid=0, and enter RUN after exactly WARMUP steps.
REQ-021 SHALL, in RUN, hold out_valid=1, step all channels only on a cycle where out_valid&&out_ready, and hold state and out_data stable otherwise.
REQ-022 SHALL, on halt in WARMUP or RUN, return to IDLE on the next edge with no step that cycle; halt has priority over out_ready, and halt in IDLE is a no-op.
REQ-023 SHALL ignore seed_wr outside IDLE, and ignore seed_wr with seed_ch>=N_CH.
REQ-024 SHALL enforce seed minimums: a written word with s0<2, s1<8 or s2<16 is replaced by that word's default for the channel; other words are stored as written.
REQ-025 SHALL, when seed_wr and start occur in the same IDLE cycle, store the seed and enter WARMUP; the first step uses the new seed.
REQ-026 SHALL give all channels a common step enable; channels never desynchronise.

Reset
REQ-027 SHALL, on re_set=1 at an edge, enter IDLE with out_valid=0 and busy=0, clear the warm-up counter, and load default seeds for channel c: s0=32'd12345+c, s1=32'd67890+c, s2=32'd13579+c; out_data then equals the defaults' XOR result.
REQ-028 SHALL give re_set priority over every other input, including mid-WARMUP and mid-RUN.

Structure
REQ-029 SHALL place the masks, shift amounts, default seed bases, seed minimums and the FSM state enum in package taus_pkg.
REQ-030 SHALL implement the single-channel combinational step (REQ-015) as sub-module taus88_step, instantiated N_CH times.

Verification
REQ-031 SHALL cover reset: re_set 1 cycle -> out_valid=0, busy=0, and ch0 state 12345/67890/13579.
REQ-032 SHALL cover warm-up timing: start with WARMUP=16 -> busy=1 for exactly 16 cycles, out_valid rises at cycle 17, and the first out_data equals the golden taus88 model after 16 steps.
REQ-033 SHALL cover backpressure: out_ready=0 for 5 cycles in RUN -> out_data constant, then 10 accepted beats match golden steps 17..26.
REQ-034 SHALL cover seed clamp: seed_wr ch1 with s0=1, s1=100, s2=3 -> stored state 12346/100/13580.
REQ-035 SHALL cover simultaneous seed_wr, start and mid-run halt: seed_wr+start with seeds 1000/2000/3000 -> output matches golden from those seeds; halt in RUN -> out_valid=0 next cycle, and start resumes the sequence without loss after a new WARMUP.
REQ-036 SHALL cover re_set asserted during RUN -> next cycle IDLE with default seeds, and a seed_wr in RUN is ignored.
